simd_execution_pipe: RTL and testbench

//  Parametrised, pipelined successor to the combinational 8-lane pixel execution stage.

---
 rtl/simd_pkg.sv | 23 ++
 rtl/simd_execution_pipe_if.sv | 33 +++
 rtl/simd_lane_alu.sv | 65 ++++++
 rtl/simd_execution_pipe.sv | 97 +++++++++
 tb/tb_simd_execution_pipe.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD pixel execution pipe: opcode width and per-lane opcode encodings.
package simd_pkg;

  localparam int BITS_ALUOP = 4;

  localparam logic [BITS_ALUOP-1:0] OP_ADD     = 4'd0;
  localparam logic [BITS_ALUOP-1:0] OP_ADDS    = 4'd1;
  localparam logic [BITS_ALUOP-1:0] OP_SUB     = 4'd2;
  localparam logic [BITS_ALUOP-1:0] OP_SUBS    = 4'd3;
  localparam logic [BITS_ALUOP-1:0] OP_AND     = 4'd4;
  localparam logic [BITS_ALUOP-1:0] OP_OR      = 4'd5;
  localparam logic [BITS_ALUOP-1:0] OP_XOR     = 4'd6;
  localparam logic [BITS_ALUOP-1:0] OP_NOT     = 4'd7;
  localparam logic [BITS_ALUOP-1:0] OP_SHL     = 4'd8;
  localparam logic [BITS_ALUOP-1:0] OP_SHR     = 4'd9;
  localparam logic [BITS_ALUOP-1:0] OP_MIN     = 4'd10;
  localparam logic [BITS_ALUOP-1:0] OP_MAX     = 4'd11;
  localparam logic [BITS_ALUOP-1:0] OP_AVG     = 4'd12;
  localparam logic [BITS_ALUOP-1:0] OP_ABSDIFF = 4'd13;
  localparam logic [BITS_ALUOP-1:0] OP_PASSA   = 4'd14;
  localparam logic [BITS_ALUOP-1:0] OP_PASSB   = 4'd15;

endpackage

// File: rtl/simd_execution_pipe_if.sv
// Operand/result handshake bundle between operand fetch, the SIMD execution pipe and writeback.
interface simd_execution_pipe_if #(
  parameter int LANES      = 8,
  parameter int BITS_PIXEL = 8
);
  import simd_pkg::*;

  localparam int BITS_ARRAY = LANES * BITS_PIXEL;

  logic                    in_valid;
  logic                    in_ready;
  logic [BITS_ALUOP-1:0]   aluOP;
  logic [BITS_ARRAY-1:0]   arrayA;
  logic [BITS_ARRAY-1:0]   arrayB;
  logic                    out_valid;
  logic                    out_ready;
  logic [BITS_ARRAY-1:0]   executionResult;
  logic [LANES-1:0]        sat_lanes;
  logic [LANES-1:0]        sat_sticky;
  logic                    clr_sticky;
  logic [15:0]             beat_count;

  modport master (
    output in_valid, aluOP, arrayA, arrayB, out_ready, clr_sticky,
    input  in_ready, out_valid, executionResult, sat_lanes, sat_sticky, beat_count
  );

  modport slave (
    input  in_valid, aluOP, arrayA, arrayB, out_ready, clr_sticky,
    output in_ready, out_valid, executionResult, sat_lanes, sat_sticky, beat_count
  );

endinterface

// File: rtl/simd_lane_alu.sv
// Combinational single-lane pixel ALU: one unsigned pixel result plus a saturation flag.
module simd_lane_alu
  import simd_pkg::*;
#(
  parameter int BITS_PIXEL = 8
) (
  input  logic [BITS_ALUOP-1:0]  aluOP,
  input  logic [BITS_PIXEL-1:0]  a,
  input  logic [BITS_PIXEL-1:0]  b,
  output logic [BITS_PIXEL-1:0]  result,
  output logic                   sat
);

  localparam int N = BITS_PIXEL;
  localparam logic [N-1:0] MAXV = '1;
  localparam logic [N-1:0] NMOD = N'(N);

  // Saturating helpers return {sat, value}.
  function automatic logic [N:0] sat_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[N] ? {1'b1, MAXV} : s;
  endfunction

  function automatic logic [N:0] sat_sub(input logic [N-1:0] x, input logic [N-1:0] y);
    return (y > x) ? {1'b1, {N{1'b0}}} : {1'b0, x - y};
  endfunction

  logic [N:0]   adds;
  logic [N:0]   subs;
  logic [N-1:0] shamt;
  logic [N-1:0] avg;
  logic [N-1:0] absd;

  always_comb begin
    adds   = sat_add(a, b);
    subs   = sat_sub(a, b);
    shamt  = b % NMOD;
    // (a+b+1)>>1 without needing an N+1 bit intermediate
    avg    = (a >> 1) + (b >> 1) + {{(N-1){1'b0}}, a[0] | b[0]};
    absd   = (a >= b) ? (a - b) : (b - a);
    result = a;
    sat    = 1'b0;
    case (aluOP)
      OP_ADD:     result = a + b;
      OP_ADDS:    begin result = adds[N-1:0]; sat = adds[N]; end
      OP_SUB:     result = a - b;
      OP_SUBS:    begin result = subs[N-1:0]; sat = subs[N]; end
      OP_AND:     result = a & b;
      OP_OR:      result = a | b;
      OP_XOR:     result = a ^ b;
      OP_NOT:     result = ~a;
      OP_SHL:     result = a << shamt;
      OP_SHR:     result = a >> shamt;
      OP_MIN:     result = (a < b) ? a : b;
      OP_MAX:     result = (a > b) ? a : b;
      OP_AVG:     result = avg;
      OP_ABSDIFF: result = absd;
      OP_PASSA:   result = a;
      OP_PASSB:   result = b;
      default:    result = a;
    endcase
  end

endmodule

// File: rtl/simd_execution_pipe.sv
// Two-stage valid/ready SIMD pixel execution pipe with sticky per-lane saturation status and beat counter.
module simd_execution_pipe
  import simd_pkg::*;
#(
  parameter int BITS_PIXEL = 8,
  parameter int LANES      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  simd_execution_pipe_if.slave   bus
);

  localparam int BITS_ARRAY = LANES * BITS_PIXEL;

  logic                    vld_p1_q;
  logic [BITS_ALUOP-1:0]   op_p1_q;
  logic [BITS_ARRAY-1:0]   a_p1_q;
  logic [BITS_ARRAY-1:0]   b_p1_q;
  logic                    vld_p2_q;
  logic [BITS_ARRAY-1:0]   res_p2_q;
  logic [LANES-1:0]        sat_p2_q;
  logic [LANES-1:0]        sticky_q, sticky_d;
  logic [15:0]             count_q, count_d;

  logic                    s1_adv, s2_adv, out_xfer;
  logic [BITS_ARRAY-1:0]   res_d;
  logic [LANES-1:0]        sat_d;

  // No skid buffer: ready ripples straight back from out_ready.
  assign s2_adv   = !vld_p2_q || bus.out_ready;
  assign s1_adv   = !vld_p1_q || s2_adv;
  assign out_xfer = vld_p2_q && bus.out_ready;

  assign bus.in_ready        = s1_adv;
  assign bus.out_valid       = vld_p2_q;
  assign bus.executionResult = res_p2_q;
  assign bus.sat_lanes       = sat_p2_q;
  assign bus.sat_sticky      = sticky_q;
  assign bus.beat_count      = count_q;

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         vld_p1_q <= 1'b0;
    else if (s1_adv) vld_p1_q <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      op_p1_q <= bus.aluOP;
      a_p1_q  <= bus.arrayA;
      b_p1_q  <= bus.arrayB;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    simd_lane_alu #(.BITS_PIXEL(BITS_PIXEL)) u_alu (
      .aluOP  (op_p1_q),
      .a      (a_p1_q[g*BITS_PIXEL +: BITS_PIXEL]),
      .b      (b_p1_q[g*BITS_PIXEL +: BITS_PIXEL]),
      .result (res_d[g*BITS_PIXEL +: BITS_PIXEL]),
      .sat    (sat_d[g])
    );
  end

  // ---- Stage 2: lane results ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
      sat_p2_q <= '0;
    end else if (s2_adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        res_p2_q <= res_d;
        sat_p2_q <= sat_d;
      end
    end
  end

  // Clear takes effect before the OR so a same-cycle transfer survives the clear.
  always_comb begin
    sticky_d = bus.clr_sticky ? '0 : sticky_q;
    if (out_xfer) sticky_d = sticky_d | sat_p2_q;
    count_d = out_xfer ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_simd_execution_pipe.sv
// Scoreboard bench for simd_execution_pipe: directed beats push expected results, a monitor pops on each output transfer.
module tb_simd_execution_pipe;
  import simd_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic [7:0]  sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simd_execution_pipe_if #(.LANES(8), .BITS_PIXEL(8)) bus ();

  simd_execution_pipe #(.BITS_PIXEL(8), .LANES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc_cyc = 0;
  int   rise_cyc = 0;
  int   run = 0;
  int   max_run = 0;
  bit   arm = 1'b0;
  bit   prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] er, input logic [7:0] es);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.aluOP    = op;
    bus.arrayA   = a;
    bus.arrayB   = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back('{res: er, sat: es});
        acc_cnt++;
        if (arm) begin acc_cyc = cyc; arm = 1'b0; end
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance within 200 cycles");
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops one expectation per output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        run++;
        if (run > max_run) max_run = run;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", bus.executionResult);
        end else begin
          e = q.pop_front();
          chk("result", bus.executionResult, e.res);
          chk("sat_lanes", {56'd0, bus.sat_lanes}, {56'd0, e.sat});
        end
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  logic [7:0] exp16 [16] = '{8'h1D, 8'hFF, 8'h69, 8'h69, 8'h42, 8'hDB, 8'h99, 8'h3C,
                             8'h0C, 8'h30, 8'h5A, 8'hC3, 8'h8F, 8'h69, 8'hC3, 8'h5A};

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.aluOP = '0; bus.arrayA = '0; bus.arrayB = '0;
    bus.out_ready = 1'b0; bus.clr_sticky = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", bus.executionResult, 64'd0);
    chk("rst_sat_lanes", {56'd0, bus.sat_lanes}, 64'd0);
    chk("rst_sat_sticky", {56'd0, bus.sat_sticky}, 64'd0);
    chk("rst_beat_count", {48'd0, bus.beat_count}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1 bus.out_ready = 1'b1;

    // ADDS saturates every lane, ADD wraps
    send(OP_ADDS, {8{8'hF0}}, {8{8'h20}}, {8{8'hFF}}, 8'hFF); idle(); drain();
    chk("sticky_after_adds", {56'd0, bus.sat_sticky}, 64'hFF);
    send(OP_ADD, {8{8'hF0}}, {8{8'h20}}, {8{8'h10}}, 8'h00); idle(); drain();
    chk("sticky_after_add", {56'd0, bus.sat_sticky}, 64'hFF);

    // SUBS with only lane 0 underflowing
    send(OP_SUBS, {{7{8'h09}}, 8'h05}, {{7{8'h05}}, 8'h09}, {{7{8'h04}}, 8'h00}, 8'h01);
    idle(); drain();
    chk("beat_count_3", {48'd0, bus.beat_count}, 64'd3);
    bus.clr_sticky = 1'b1;
    @(posedge clk); #1 bus.clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", {56'd0, bus.sat_sticky}, 64'h00);
    @(posedge clk); #1;
    send(OP_SUBS, {{7{8'h09}}, 8'h05}, {{7{8'h05}}, 8'h09}, {{7{8'h04}}, 8'h00}, 8'h01);
    idle(); drain();
    chk("sticky_subs_only", {56'd0, bus.sat_sticky}, 64'h01);

    // Edge opcodes back to back
    send(OP_SHL, {8{8'h81}}, {8{8'h09}}, {8{8'h02}}, 8'h00);
    send(OP_AVG, {8{8'hFF}}, {8{8'hFF}}, {8{8'hFF}}, 8'h00);
    send(OP_ABSDIFF, {8{8'h10}}, {8{8'hF0}}, {8{8'hE0}}, 8'h00);
    idle(); drain();
    chk("sticky_after_edge", {56'd0, bus.sat_sticky}, 64'h01);
    chk("beat_count_7", {48'd0, bus.beat_count}, 64'd7);

    // All 16 opcodes back to back from a fresh reset
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    max_run = 0; arm = 1'b1;
    for (int i = 0; i < 16; i++)
      send(4'(i), {8{8'hC3}}, {8{8'h5A}}, {8{exp16[i]}}, (i == 1) ? 8'hFF : 8'h00);
    idle(); drain();
    chk("latency", 64'(rise_cyc - acc_cyc), 64'd2);
    chk("consecutive_run", 64'(max_run), 64'd16);
    chk("beat_count_16", {48'd0, bus.beat_count}, 64'd16);

    // Stall with in_valid held
    bus.out_ready = 1'b0; acc_cnt = 0;
    fork
      begin
        send(OP_PASSA, {8{8'h11}}, 64'd0, {8{8'h11}}, 8'h00);
        send(OP_PASSA, {8{8'h22}}, 64'd0, {8{8'h22}}, 8'h00);
        send(OP_PASSA, {8{8'h33}}, 64'd0, {8{8'h33}}, 8'h00);
        send(OP_PASSA, {8{8'h44}}, 64'd0, {8{8'h44}}, 8'h00);
        idle();
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
          chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
          chk("stall_hold", bus.executionResult, {8{8'h11}});
        end
        chk("stall_accepted", 64'(acc_cnt), 64'd2);
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("beat_count_20", {48'd0, bus.beat_count}, 64'd20);

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    send(OP_PASSA, {8{8'h55}}, 64'd0, {8{8'h55}}, 8'h00);
    send(OP_PASSA, {8{8'h66}}, 64'd0, {8{8'h66}}, 8'h00);
    idle();
    chk("inflight_out_valid", {63'd0, bus.out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("async_rst_beat_count", {48'd0, bus.beat_count}, 64'd0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0; bus.out_ready = 1'b1;
    send(OP_ADD, {8{8'h01}}, {8{8'h02}}, {8{8'h03}}, 8'h00); idle(); drain();
    chk("post_rst_beat_count", {48'd0, bus.beat_count}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
